// File: rtl/tmr_inj_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tmr_inj_sched_if
// Brief    : Control/status bundle between a campaign host and tmr_inj_sched.
// Revision : 1.0
// ============================================================================
interface tmr_inj_sched_if #(
  parameter int LEN_W  = 8,
  parameter int NWIN_W = 4,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  win_len;
  logic [LEN_W-1:0]  gap_len;
  logic [NWIN_W-1:0] n_win;
  logic              err_det;

  logic              inj_en;
  logic              busy;
  logic              done;
  logic [NWIN_W-1:0] win_idx;
  logic [CNT_W-1:0]  det_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    output start, abort, win_len, gap_len, n_win, err_det,
    input  inj_en, busy, done, win_idx, det_cnt, miss_cnt
  );

  modport slave (
    input  start, abort, win_len, gap_len, n_win, err_det,
    output inj_en, busy, done, win_idx, det_cnt, miss_cnt
  );
endinterface
`default_nettype wire

// File: rtl/tmr_inj_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tmr_inj_sched
// Brief    : Injection-window campaign scheduler; classifies each window as
//            detected or missed from the TMR voter mismatch flag.
// Revision : 1.0
// ============================================================================
module tmr_inj_sched #(
  parameter int LEN_W  = 8,
  parameter int NWIN_W = 4,
  parameter int CNT_W  = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  tmr_inj_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_INJECT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

  state_t            r_state;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_win_len;
  logic [LEN_W-1:0]  r_gap_len;
  logic [NWIN_W-1:0] r_n_win;
  logic              r_det_flag;
  logic [NWIN_W-1:0] r_win_idx;
  logic [CNT_W-1:0]  r_det_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic              r_inj_en;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_nxt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic [LEN_W-1:0]  w_win_len_nxt;
  logic [LEN_W-1:0]  w_gap_len_nxt;
  logic [NWIN_W-1:0] w_n_win_nxt;
  logic              w_det_flag_nxt;
  logic [NWIN_W-1:0] w_win_idx_nxt;
  logic [CNT_W-1:0]  w_det_cnt_nxt;
  logic [CNT_W-1:0]  w_miss_cnt_nxt;

  logic              w_last;
  logic              w_hit;
  logic              w_last_win;
  logic [LEN_W-1:0]  w_gap_load_new;
  logic [LEN_W-1:0]  w_gap_load;
  logic [LEN_W-1:0]  w_win_load;
  logic [CNT_W-1:0]  w_det_inc;
  logic [CNT_W-1:0]  w_miss_inc;

  // Zero-length fields behave as one cycle so every phase is always visible.
  assign w_gap_load_new = (bus.gap_len == '0) ? c_len_one : bus.gap_len;
  assign w_gap_load     = (r_gap_len == '0)   ? c_len_one : r_gap_len;
  assign w_win_load     = (r_win_len == '0)   ? c_len_one : r_win_len;

  assign w_last     = (r_cnt == c_len_one);
  assign w_hit      = r_det_flag | bus.err_det;
  assign w_last_win = (r_win_idx == (r_n_win - NWIN_W'(1)));
  assign w_det_inc  = (r_det_cnt == c_cnt_max)  ? r_det_cnt  : r_det_cnt + CNT_W'(1);
  assign w_miss_inc = (r_miss_cnt == c_cnt_max) ? r_miss_cnt : r_miss_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_win_len_nxt  = r_win_len;
    w_gap_len_nxt  = r_gap_len;
    w_n_win_nxt    = r_n_win;
    w_det_flag_nxt = r_det_flag;
    w_win_idx_nxt  = r_win_idx;
    w_det_cnt_nxt  = r_det_cnt;
    w_miss_cnt_nxt = r_miss_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (!bus.abort && bus.start) begin
          w_win_len_nxt  = bus.win_len;
          w_gap_len_nxt  = bus.gap_len;
          w_n_win_nxt    = bus.n_win;
          w_win_idx_nxt  = '0;
          w_det_cnt_nxt  = '0;
          w_miss_cnt_nxt = '0;
          if (bus.n_win == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = w_gap_load_new;
          end
        end
      end

      ST_GAP: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt    = ST_INJECT;
          w_cnt_nxt      = w_win_load;
          w_det_flag_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - c_len_one;
        end
      end

      ST_INJECT: begin
        // An aborted window is dropped without touching either counter.
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_det_flag_nxt = w_hit;
          if (w_last) begin
            if (w_hit) begin
              w_det_cnt_nxt = w_det_inc;
            end else begin
              w_miss_cnt_nxt = w_miss_inc;
            end
            w_det_flag_nxt = 1'b0;
            if (w_last_win) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_win_idx_nxt = r_win_idx + NWIN_W'(1);
              w_state_nxt   = ST_GAP;
              w_cnt_nxt     = w_gap_load;
            end
          end else begin
            w_cnt_nxt = r_cnt - c_len_one;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_win_len  <= '0;
      r_gap_len  <= '0;
      r_n_win    <= '0;
      r_det_flag <= 1'b0;
      r_win_idx  <= '0;
      r_det_cnt  <= '0;
      r_miss_cnt <= '0;
      r_inj_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_win_len  <= w_win_len_nxt;
      r_gap_len  <= w_gap_len_nxt;
      r_n_win    <= w_n_win_nxt;
      r_det_flag <= w_det_flag_nxt;
      r_win_idx  <= w_win_idx_nxt;
      r_det_cnt  <= w_det_cnt_nxt;
      r_miss_cnt <= w_miss_cnt_nxt;
      r_inj_en   <= (w_state_nxt == ST_INJECT);
      r_busy     <= (w_state_nxt == ST_GAP) || (w_state_nxt == ST_INJECT);
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.inj_en   = r_inj_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.win_idx  = r_win_idx;
  assign bus.det_cnt  = r_det_cnt;
  assign bus.miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tmr_inj_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tmr_inj_sched
// Brief    : Directed bench for tmr_inj_sched (8-bit and 2-bit counter builds).
// Revision : 1.0
// ============================================================================
module tb_tmr_inj_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] win_len;
  logic [7:0] gap_len;
  logic [3:0] n_win;
  logic       err_det;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  tmr_inj_sched_if #(.LEN_W(8), .NWIN_W(4), .CNT_W(8)) if8 ();
  tmr_inj_sched_if #(.LEN_W(8), .NWIN_W(4), .CNT_W(2)) if2 ();

  assign if8.start   = start;
  assign if8.abort   = abort;
  assign if8.win_len = win_len;
  assign if8.gap_len = gap_len;
  assign if8.n_win   = n_win;
  assign if8.err_det = err_det;
  assign if2.start   = start;
  assign if2.abort   = abort;
  assign if2.win_len = win_len;
  assign if2.gap_len = gap_len;
  assign if2.n_win   = n_win;
  assign if2.err_det = err_det;

  tmr_inj_sched #(.LEN_W(8), .NWIN_W(4), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  tmr_inj_sched #(.LEN_W(8), .NWIN_W(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Campaign model: phase 0 idle, 1 running, 2 done cycle; m_t counts cycles
  // since the accepted start, and window boundaries follow from G+W.
  int m_ph, m_t, m_g, m_w, m_n, m_idx, m_det, m_miss;
  bit m_hit;

  initial begin
    m_ph = 0; m_t = 0; m_g = 1; m_w = 1; m_n = 0;
    m_idx = 0; m_det = 0; m_miss = 0; m_hit = 1'b0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_ph = 0; m_t = 0; m_idx = 0; m_det = 0; m_miss = 0; m_hit = 1'b0;
      end else begin
        case (m_ph)
          0: if (!abort && start) begin
            m_g = (gap_len == 0) ? 1 : int'(gap_len);
            m_w = (win_len == 0) ? 1 : int'(win_len);
            m_n = int'(n_win);
            m_idx = 0; m_det = 0; m_miss = 0; m_hit = 1'b0; m_t = 1;
            m_ph = (m_n == 0) ? 2 : 1;
          end
          1: if (abort) begin
            m_ph = 0;
          end else begin
            int p, r, k;
            p = m_g + m_w;
            r = (m_t - 1) % p;
            k = (m_t - 1) / p;
            if (r >= m_g && err_det) m_hit = 1'b1;
            if (r == p - 1) begin
              if (m_hit) m_det++; else m_miss++;
              m_hit = 1'b0;
              if (k == m_n - 1) m_ph = 2; else m_idx = k + 1;
            end
            m_t++;
          end
          default: m_ph = 0;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        logic e_inj;
        e_inj = 1'b0;
        if (m_ph == 1) e_inj = (((m_t - 1) % (m_g + m_w)) >= m_g);
        chk("inj_en",    if8.inj_en,   e_inj);
        chk("busy",      if8.busy,     m_ph == 1);
        chk("done",      if8.done,     m_ph == 2);
        chk("win_idx",   if8.win_idx,  m_idx);
        chk("det_cnt",   if8.det_cnt,  (m_det > 255) ? 255 : m_det);
        chk("miss_cnt",  if8.miss_cnt, (m_miss > 255) ? 255 : m_miss);
        chk("inj_en_c2", if2.inj_en,   e_inj);
        chk("det_c2",    if2.det_cnt,  (m_det > 3) ? 3 : m_det);
        chk("miss_c2",   if2.miss_cnt, (m_miss > 3) ? 3 : m_miss);
      end
    end
  end

  // Runs one campaign for ncyc cycles after the start edge; bit c of the
  // masks records the output level seen in cycle c.
  task automatic campaign(input int g, input int w, input int n, input logic [31:0] det_mask,
                          input int abort_c, input int restart_c, input int ncyc,
                          output logic [31:0] inj_m, output logic [31:0] busy_m, output int done_c);
    inj_m = '0; busy_m = '0; done_c = 0;
    @(negedge clk);
    gap_len = 8'(g); win_len = 8'(w); n_win = 4'(n);
    err_det = 1'b0; abort = 1'b0; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (if8.inj_en) inj_m[c] = 1'b1;
      if (if8.busy) busy_m[c] = 1'b1;
      if (if8.done && done_c == 0) done_c = c;
      start   = (c == restart_c);
      abort   = (c == abort_c);
      err_det = det_mask[c];
    end
  endtask

  logic [31:0] inj_m, busy_m;
  int done_c;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; err_det = 1'b0;
    win_len = '0; gap_len = '0; n_win = '0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", if8.busy, 0);
    chk("rst_inj", if8.inj_en, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic campaign, no detections
    campaign(3, 2, 2, 32'h0, -1, -1, 11, inj_m, busy_m, done_c);
    chk("basic_inj_mask", inj_m, 32'h630);
    chk("basic_busy_mask", busy_m, 32'h7FE);
    chk("basic_done_cyc", done_c, 11);
    chk("basic_miss", if8.miss_cnt, 2);
    chk("basic_det", if8.det_cnt, 0);

    // Detection on the last cycle of window 0
    campaign(3, 2, 2, 32'h20, -1, -1, 11, inj_m, busy_m, done_c);
    chk("det_last_det", if8.det_cnt, 1);
    chk("det_last_miss", if8.miss_cnt, 1);

    // Detection during GAP only is ignored
    campaign(3, 2, 2, 32'h40, -1, -1, 11, inj_m, busy_m, done_c);
    chk("det_gap_det", if8.det_cnt, 0);
    chk("det_gap_miss", if8.miss_cnt, 2);

    // Zero lengths
    campaign(0, 0, 1, 32'h0, -1, -1, 3, inj_m, busy_m, done_c);
    chk("zero_inj_mask", inj_m, 32'h4);
    chk("zero_done_cyc", done_c, 3);

    // Empty campaign
    campaign(2, 2, 0, 32'h0, -1, -1, 1, inj_m, busy_m, done_c);
    chk("empty_done_cyc", done_c, 1);
    chk("empty_busy", busy_m, 0);
    repeat (3) @(negedge clk);
    chk("empty_inj_never", inj_m | {31'b0, if8.inj_en}, 0);

    // Abort in cycle 7 with an ignored restart while busy
    campaign(1, 4, 3, 32'h0, 7, 3, 12, inj_m, busy_m, done_c);
    chk("abort_inj_mask", inj_m, 32'hBC);
    chk("abort_busy_mask", busy_m, 32'hFE);
    chk("abort_no_done", done_c, 0);
    chk("abort_windows", if8.det_cnt + if8.miss_cnt, 1);

    // start together with abort in IDLE is ignored
    @(negedge clk);
    gap_len = 8'd1; win_len = 8'd1; n_win = 4'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", if8.busy, 0);
    chk("start_abort_miss_hold", if8.miss_cnt, 1);

    // Saturation of the 2-bit counter build
    campaign(1, 1, 5, 32'hFFFF_FFFF, -1, -1, 11, inj_m, busy_m, done_c);
    err_det = 1'b0;
    chk("sat_inj_mask", inj_m, 32'h554);
    chk("sat_done_cyc", done_c, 11);
    chk("sat_det_c2", if2.det_cnt, 3);
    chk("sat_det_c8", if8.det_cnt, 5);
    chk("sat_miss_c2", if2.miss_cnt, 0);

    // Asynchronous reset in the middle of an INJECT cycle
    campaign(1, 1, 3, 32'h0, -1, -1, 4, inj_m, busy_m, done_c);
    chk("pre_rst_inj", if8.inj_en, 1);
    chk("pre_rst_miss", if8.miss_cnt, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_inj", if8.inj_en, 0);
    chk("arst_busy", if8.busy, 0);
    chk("arst_done", if8.done, 0);
    chk("arst_miss", if8.miss_cnt, 0);
    chk("arst_idx", if8.win_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", if8.busy, 0);

    // Recovery campaign after reset
    campaign(3, 2, 2, 32'h200, -1, -1, 11, inj_m, busy_m, done_c);
    chk("recov_inj_mask", inj_m, 32'h630);
    chk("recov_det", if8.det_cnt, 1);
    chk("recov_miss", if8.miss_cnt, 1);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/tmr_inj_sched.md
# tmr_inj_sched

Error-injection campaign scheduler for the Dynamic TMR datapath. It drives the injection-enable input (`state`) of the command error injector. It runs a programmed number of injection windows separated by idle gaps, and classifies each window as detected or missed using the voter mismatch flag. Software or a testbench starts a campaign with a start pulse and reads back the counters after `done`.

## Interface
Parameters:
- `len_w`, 8: width of window/gap length fields.
- `nwin_w`, 4: width of window count and window index.
- `cnt_w`, 8: width of detected/missed counters (saturating).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserts immediately when low, released synchronously by design usage).
- `start`  in  1  campaign start; sampled only in IDLE.
- `abort`  in  1  terminate campaign; highest priority after reset.
- `win_len`  in  len_w  injection window length in cycles (0 treated as 1).
- `gap_len`  in  len_w  idle gap before each window in cycles (0 treated as 1).
- `n_win`  in  nwin_w  number of windows; 0 = empty campaign.
- `err_det`  in  1  voter mismatch flag from TMR voter.
- `inj_en`  out  1  injection enable, connects to the injector `state` input.
- `busy`  out  1  high in GAP/INJECT.
- `done`  out  1  one-cycle pulse at normal campaign completion.
- `win_idx`  out  nwin_w  index of current window (0-based).
- `det_cnt`  out  cnt_w  windows in which `err_det` was seen.
- `miss_cnt`  out  cnt_w  windows with no `err_det`.

## Operation
- FSM states: IDLE, GAP, INJECT, DONE. All outputs are registered.
- Reset (`rst` low): state=IDLE; `inj_en`, `busy`, `done`=0; `win_idx`, `det_cnt`, `miss_cnt`, length counter=0; window-detect flag=0.
- IDLE: on `start`=1, latch `win_len`, `gap_len`, `n_win` and clear `win_idx`, `det_cnt`, `miss_cnt`.
  - If latched `n_win`=0, go to DONE.
  - Otherwise go to GAP and load the counter with max(gap_len,1).
  - Config inputs are ignored outside IDLE.
- GAP: `inj_en`=0, `busy`=1. Decrement the counter. At the last gap cycle, go to INJECT, load the counter with max(win_len,1), and clear the detect flag.
- INJECT: `inj_en`=1, `busy`=1. Any cycle with `err_det`=1 sets the detect flag. A detection arriving on the last INJECT cycle counts for that window.
  - At the last INJECT cycle, increment `det_cnt` if the flag (including the current cycle) is set; otherwise increment `miss_cnt`. Both counters saturate at 2^cnt_w−1.
  - If `win_idx`=n_win−1, go to DONE. Otherwise increment `win_idx` and go to GAP.
- DONE: `done`=1 for exactly one cycle, `busy`=0, `inj_en`=0, then go to IDLE.
- `err_det` outside INJECT is ignored.
- Counters and `win_idx` hold their values in IDLE until the next accepted `start`.
- `abort`=1 in GAP/INJECT/DONE forces IDLE on the next edge. It drops `inj_en`/`busy` and asserts no `done`. Counters keep partial values, and the partially completed window is not counted. `abort` in IDLE has no effect. `abort` and `start` together in IDLE: abort wins, so start is ignored.
- `start` while not in IDLE is ignored. There is no queueing.

## Timing
- Edge E0 samples `start`=1 in IDLE. From cycle 1, `busy`=1.
- Per window, with G=max(gap_len,1) and W=max(win_len,1): G cycles of GAP, then W cycles of INJECT.
- `inj_en` is high for cycles k·(G+W)+G+1 … (k+1)·(G+W), for k=0…n_win−1.
- `det_cnt`/`miss_cnt` update visibly in the cycle after each window's last INJECT cycle.
- `done` is high in cycle n_win·(G+W)+1. `busy` is low in that cycle. IDLE is in effect from the following cycle, and a new `start` is accepted there.
- Empty campaign (`n_win`=0): `done` is high in cycle 1 with `busy`=0 throughout.
- Async reset mid-campaign: all outputs reach reset values without waiting for a clock edge. `inj_en` must never glitch high during reset.

## Test plan
- Reset: drive `rst` low mid-INJECT → `inj_en`, `busy`, `done`, counters go to 0 immediately; after release the FSM is in IDLE.
- Basic campaign: gap_len=3, win_len=2, n_win=2, `err_det` tied 0 → `inj_en` high in cycles 4–5 and 9–10; `done` in cycle 11; miss_cnt=2, det_cnt=0.
- Detection: same config, `err_det` pulsed only in cycle 5 (last cycle of window 0) → det_cnt=1, miss_cnt=1; a pulse in cycle 6 (GAP) alone → det_cnt=0.
- Zero fields: gap_len=0, win_len=0, n_win=1 → `inj_en` high only in cycle 2, `done` in cycle 3; n_win=0 → `done` in cycle 1, `inj_en` never high.
- Abort: gap_len=1, win_len=4, n_win=3, abort in cycle 7 → `inj_en`/`busy` low from cycle 8, no `done`; det_cnt+miss_cnt=1; `start` while busy is ignored.
- Saturation: cnt_w=2, n_win=5, gap_len=1, win_len=1, `err_det` high throughout → det_cnt=3 (saturated), miss_cnt=0, `done` in cycle 11.
